// File: rtl/slabboy_clkgen.sv
// slabboy_clkgen: PLL lock qualification, system reset sequencing and fractional clock enables.
// Optional CLKGEN_PHASE_ALIGN_EN: align clears every phase accumulator while running.
module slabboy_clkgen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    clear_lost,
    input  logic                    align,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    sys_reset_n,
    output logic                    ready,
    output logic                    lost_lock
);
    localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d, lost_q, lost_d, lk, adv;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;

    assign lk = sync_q[1];

    // The lk-high sample that leaves WAIT_LOCK is the first of the LOCK_CYCLES qualifying cycles.
    always_comb begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        case (state_q)
            WAIT_LOCK: if (lk) begin
                state_d = (LOCK_CYCLES == 1) ? RUN : STABLE;
                cnt_d   = CNT_W'(1);
            end
            STABLE: if (lk) begin
                state_d = (cnt_q == CNT_LAST) ? RUN : STABLE;
                cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            end
            RUN: state_d = lk ? RUN : WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    assign run_d  = state_d == RUN;
    assign lost_d = (state_q == RUN && !lk) || (lost_q && !clear_lost);

    // Accumulators advance only on edges that stay in RUN, so strobes stop on the leaving edge.
`ifdef CLKGEN_PHASE_ALIGN_EN
    assign adv = state_q == RUN && run_d && !align;
`else
    logic unused_align;
    assign unused_align = align;
    assign adv = state_q == RUN && run_d;
`endif

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            {en_d[k], acc_d[k]} = (adv && ch_en[k])
                ? {1'b0, acc_q[k]} + {1'b0, inc[k*ACC_W +: ACC_W]} : '0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            sync_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            lost_q  <= 1'b0;
            en_q    <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], pll_locked};
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            lost_q  <= lost_d;
            en_q    <= en_d;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
        end
    end

    assign clk_en      = en_q;
    assign sys_reset_n = run_q;
    assign ready       = run_q;
    assign lost_lock   = lost_q;
endmodule

// File: tb/tb_slabboy_clkgen.sv
// tb_slabboy_clkgen: scoreboard bench for slabboy_clkgen with a cycle-level reference model.
// Directed lock/strobe scenarios followed by randomized lock glitches, increments and enables.
module tb_slabboy_clkgen;
    localparam int NUM_CH = 2;
    localparam int ACC_W  = 24;
    localparam int LC     = 16;

    logic clk = 1'b0, reset_n = 1'b0, pll_locked = 1'b0, clear_lost = 1'b0, align = 1'b0;
    logic [NUM_CH*ACC_W-1:0] inc = '0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic [NUM_CH-1:0] clk_en;
    logic sys_reset_n, ready, lost_lock;

    int checks = 0, failures = 0;
    logic [NUM_CH+2:0] exp_q [$];

    bit     pll_hist [$];
    int     cons = 0;
    bit     run_m = 1'b0, lost_m = 1'b0;
    longint acc_m [NUM_CH];

    slabboy_clkgen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LC)) dut (
        .clock_in(clk), .reset_n(reset_n), .pll_locked(pll_locked), .inc(inc),
        .ch_en(ch_en), .clear_lost(clear_lost), .align(align), .clk_en(clk_en),
        .sys_reset_n(sys_reset_n), .ready(ready), .lost_lock(lost_lock)
    );

    always #5 clk = ~clk;

    // Reference: run means the last LC synchronised lock samples were all high.
    always @(posedge clk) begin : model
        bit lk, was_run, act;
        logic [NUM_CH-1:0] en;
        en = '0;
        if (!reset_n) begin
            pll_hist.delete();
            cons   = 0;
            run_m  = 1'b0;
            lost_m = 1'b0;
            foreach (acc_m[k]) acc_m[k] = 0;
        end else begin
            lk = (pll_hist.size() >= 2) ? pll_hist[pll_hist.size()-2] : 1'b0;
            pll_hist.push_back(pll_locked);
            if (pll_hist.size() > 2) void'(pll_hist.pop_front());
            was_run = run_m;
            cons    = lk ? cons + 1 : 0;
            run_m   = cons >= LC;
            lost_m  = (was_run && !lk) || (lost_m && !clear_lost);
            act     = was_run && run_m;
`ifdef CLKGEN_PHASE_ALIGN_EN
            act = act && !align;
`endif
            for (int k = 0; k < NUM_CH; k++) begin
                if (act && ch_en[k]) begin
                    acc_m[k] = acc_m[k] + longint'(inc[k*ACC_W +: ACC_W]);
                    en[k]    = acc_m[k] >= (longint'(1) << ACC_W);
                    acc_m[k] = acc_m[k] % (longint'(1) << ACC_W);
                end else begin
                    acc_m[k] = 0;
                end
            end
        end
        exp_q.push_back({en, run_m, run_m, lost_m});
    end

    always @(negedge clk) begin : monitor
        logic [NUM_CH+2:0] got, want;
        got = {clk_en, sys_reset_n, ready, lost_lock};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty t=%0t got=%b", $time, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL outputs t=%0t got{en,srn,rdy,lost}=%b want=%b", $time, got, want);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        #1 reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int f0, f1, n0, n1, d1, d2;
        #2 check("reset_state", int'({clk_en, sys_reset_n, ready, lost_lock}), 0);

        // Lock from reset release: release 2 sync + 16 qualifying cycles later.
        pll_locked = 1'b1;
        restart();
        f0 = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (ready && f0 < 0) f0 = i;
        end
        check("lock_latency", f0, 18);
        check("stays_ready", int'({sys_reset_n, ready}), 3);

        // One-cycle glitch seen by the FSM after 10 STABLE counts restarts qualification.
        restart();
        f0 = -1;
        for (int i = 1; i <= 40; i++) begin
            pll_locked = (i != 11);
            cyc(1);
            if (ready && f0 < 0) f0 = i;
        end
        check("glitch_latency", f0, 29);

        // Quarter and half rate channels enabled before release.
        inc = {24'h800000, 24'h400000};
        ch_en = 2'b11;
        restart();
        f0 = -1; f1 = -1; n0 = 0; n1 = 0;
        for (int i = 1; i <= 30; i++) begin
            cyc(1);
            if (clk_en[0]) begin n0++; if (f0 < 0) f0 = i; end
            if (clk_en[1]) begin n1++; if (f1 < 0) f1 = i; end
        end
        check("first_en0", f0, 22);
        check("first_en1", f1, 20);
        check("count_en0", n0, 3);
        check("count_en1", n1, 6);

        // Lock loss in RUN with a clear_lost on the very same edge.
        pll_locked = 1'b0;
        cyc(2);
        clear_lost = 1'b1;
        cyc(1);
        clear_lost = 1'b0;
        check("loss_outputs", int'({clk_en, sys_reset_n, ready, lost_lock}), 1);
        cyc(3);
        clear_lost = 1'b1;
        cyc(1);
        clear_lost = 1'b0;
        check("lost_cleared", int'(lost_lock), 0);

        // Near-full increment, then zero increment, then disable mid-run.
        pll_locked = 1'b1;
        inc = {24'h000000, 24'hFFFFFF};
        ch_en = 2'b01;
        restart();
        n0 = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (clk_en[0]) n0++;
        end
        check("full_inc_count", n0, 21);
        inc[ACC_W-1:0] = '0;
        n0 = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            if (clk_en[0]) n0++;
        end
        check("zero_inc_count", n0, 0);
        inc[ACC_W-1:0] = 24'h400000;
        cyc(8);
        ch_en = 2'b00;
        cyc(2);
        check("disabled_en", int'(clk_en), 0);

        // Equal increments started two cycles apart, then an align pulse.
        inc = {24'h555555, 24'h555555};
        ch_en = 2'b01;
        restart();
        cyc(20);
        ch_en = 2'b11;
        d1 = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (clk_en[0] != clk_en[1]) d1++;
        end
        check("offset_before_align", int'(d1 > 0), 1);
        align = 1'b1;
        cyc(1);
        align = 1'b0;
        d2 = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (clk_en[0] != clk_en[1]) d2++;
        end
`ifdef CLKGEN_PHASE_ALIGN_EN
        check("aligned_mismatch", d2, 0);
`else
        check("offset_kept", int'(d2 > 0), 1);
`endif

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", int'({clk_en, sys_reset_n, ready, lost_lock}), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomized phase: rare lock glitches, random increments, enables, align and clears.
        for (int i = 0; i < 800; i++) begin
            pll_locked = ($urandom_range(0, 249) != 0);
            clear_lost = ($urandom_range(0, 15) == 0);
            align      = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 29) == 0) ch_en = NUM_CH'($urandom);
            for (int k = 0; k < NUM_CH; k++)
                if ($urandom_range(0, 39) == 0)
                    inc[k*ACC_W +: ACC_W] = ($urandom_range(0, 3) == 0)
                        ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 32'h400000));
            cyc(1);
        end
        clear_lost = 1'b0;
        align = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
